// File: rtl/pixel_apb_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_apb_loader_pkg
// Purpose  : Shared state encoding, frame geometry and packing helper.
// Revision : 1.0
// ============================================================================
package pixel_apb_loader_pkg;

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    W_SETUP  = 3'd1,
    W_ACCESS = 3'd2,
    S_SETUP  = 3'd3,
    S_ACCESS = 3'd4,
    DONE     = 3'd5
  } loader_state_t;

  localparam int PIXELS_PER_WORD = 3;
  localparam int WORDS_PER_FRAME = 4096;
  localparam int START_REG_ADDR  = 0;
  localparam int PIXEL_WIDTH     = 8;

  // Word counter must hold WORDS_PER_FRAME itself (1..4096 inclusive).
  localparam int WORD_CNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int LANE_W     = 2;

  function automatic logic [PIXELS_PER_WORD*PIXEL_WIDTH-1:0] pack_word(
    input logic [PIXEL_WIDTH-1:0] p0,
    input logic [PIXEL_WIDTH-1:0] p1,
    input logic [PIXEL_WIDTH-1:0] p2
  );
    return {p2, p1, p0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_apb_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_apb_loader_if
// Purpose  : Pixel stream handshake plus APB write-master signals.
// Revision : 1.0
// ============================================================================
interface pixel_apb_loader_if
  import pixel_apb_loader_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12
) ();

  logic                     pix_valid;
  logic [PIXEL_WIDTH-1:0]   pix_data;
  logic                     pix_ready;
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [Amba_Addr_Depth:0] PADDR;
  logic [Amba_Word-1:0]     PWDATA;
  logic                     frame_done;
  logic                     busy;

  // The loader side.
  modport master (
    input  pix_valid, pix_data,
    output pix_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, frame_done, busy
  );

  // The environment side: pixel source, APB slave, status observer.
  modport slave (
    output pix_valid, pix_data,
    input  pix_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, frame_done, busy
  );

endinterface
`default_nettype wire

// File: rtl/pixel_apb_loader_apb_write_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_write_master
// Purpose  : Two-cycle APB write (SETUP then ACCESS) launched by a req pulse.
// Revision : 1.0
// ============================================================================
module apb_write_master
  import pixel_apb_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  // A req seen during ACCESS chains straight into the next SETUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (r_psel && !r_penable) begin
      r_penable <= 1'b1;
    end else if (req) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b1;
      r_paddr   <= addr;
      r_pwdata  <= data;
    end else begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
    end
  end

  assign done    = r_psel & r_penable;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule
`default_nettype wire

// File: rtl/pixel_apb_loader.sv
`default_nettype none
// ============================================================================
// Module   : pixel_apb_loader
// Purpose  : Packs 8-bit pixels three per word and writes a 4096-word frame
//            over APB, then kicks the start register at address 0.
// Revision : 1.0
// ============================================================================
module pixel_apb_loader
  import pixel_apb_loader_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12
) (
  input  logic               clk,
  input  logic               rst,
  pixel_apb_loader_if.master bus
);

  localparam int                    ADDR_W      = Amba_Addr_Depth + 1;
  localparam logic [WORD_CNT_W-1:0] c_last_word = WORD_CNT_W'(WORDS_PER_FRAME);
  localparam logic [LANE_W-1:0]     c_last_lane = LANE_W'(PIXELS_PER_WORD - 1);

  loader_state_t          r_state;
  logic [LANE_W-1:0]      r_lane;
  logic [WORD_CNT_W-1:0]  r_word_cnt;
  logic [PIXEL_WIDTH-1:0] r_lane0;
  logic [PIXEL_WIDTH-1:0] r_lane1;
  logic                   r_pix_ready;
  logic                   r_frame_done;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_last_lane;
  logic                   w_req_word;
  logic                   w_req_start;
  logic                   w_req;
  logic                   w_done;
  logic [ADDR_W-1:0]      w_addr;
  logic [Amba_Word-1:0]   w_data;
  logic                   w_psel;
  logic                   w_penable;
  logic                   w_pwrite;
  logic [ADDR_W-1:0]      w_paddr;
  logic [Amba_Word-1:0]   w_pwdata;

  // pix_ready is only ever high in FILL, so accept implies FILL.
  assign w_accept    = bus.pix_valid & r_pix_ready;
  assign w_last_lane = (r_lane == c_last_lane);
  assign w_req_word  = w_accept & w_last_lane;
  assign w_req_start = (r_state == W_ACCESS) & w_done & (r_word_cnt == c_last_word);
  assign w_req       = w_req_word | w_req_start;

  // The lane-2 pixel goes straight from the bus into the word being launched.
  assign w_addr = w_req_start ? ADDR_W'(START_REG_ADDR) : ADDR_W'(r_word_cnt);
  assign w_data = w_req_start ? Amba_Word'(1)
                              : Amba_Word'(pack_word(r_lane0, r_lane1, bus.pix_data));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FILL;
      r_lane       <= '0;
      r_word_cnt   <= WORD_CNT_W'(1);
      r_lane0      <= '0;
      r_lane1      <= '0;
      r_pix_ready  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FILL: begin
          r_pix_ready <= 1'b1;
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_last_lane) begin
              r_lane      <= '0;
              r_pix_ready <= 1'b0;
              r_state     <= W_SETUP;
            end else begin
              r_lane <= r_lane + LANE_W'(1);
              if (r_lane == '0) r_lane0 <= bus.pix_data;
              else              r_lane1 <= bus.pix_data;
            end
          end
        end
        W_SETUP: r_state <= W_ACCESS;
        W_ACCESS: begin
          if (w_done) begin
            if (r_word_cnt == c_last_word) begin
              r_state <= S_SETUP;
            end else begin
              r_word_cnt  <= r_word_cnt + WORD_CNT_W'(1);
              r_pix_ready <= 1'b1;
              r_state     <= FILL;
            end
          end
        end
        S_SETUP: r_state <= S_ACCESS;
        S_ACCESS: begin
          if (w_done) begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_word_cnt  <= WORD_CNT_W'(1);
          r_lane      <= '0;
          r_pix_ready <= 1'b1;
          r_state     <= FILL;
        end
        default: begin
          r_pix_ready <= 1'b0;
          r_state     <= FILL;
        end
      endcase
    end
  end

  apb_write_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (Amba_Word)
  ) u_apb_write_master (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .addr    (w_addr),
    .data    (w_data),
    .done    (w_done),
    .psel    (w_psel),
    .penable (w_penable),
    .pwrite  (w_pwrite),
    .paddr   (w_paddr),
    .pwdata  (w_pwdata)
  );

  assign bus.pix_ready  = r_pix_ready;
  assign bus.PSEL       = w_psel;
  assign bus.PENABLE    = w_penable;
  assign bus.PWRITE     = w_pwrite;
  assign bus.PADDR      = w_paddr;
  assign bus.PWDATA     = w_pwdata;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pixel_apb_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_apb_loader
// Purpose  : Directed self-checking bench for pixel_apb_loader.
// Revision : 1.0
// ============================================================================
module tb_pixel_apb_loader;

  localparam int AW        = 24;
  localparam int AD        = 12;
  localparam int AW_ADDR   = AD + 1;
  localparam int FRAME_PIX = 12288;
  localparam int FRAME_WRD = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int fd_cnt   = 0;
  int fd_cyc   = -1;

  logic [AD:0]   wr_addr_q[$];
  logic [AW-1:0] wr_data_q[$];
  int            acc_q[$];
  logic [7:0]    pix_q[$];

  pixel_apb_loader_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) bus ();

  pixel_apb_loader #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // APB slave-side log of completed writes and frame_done high cycles.
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      wr_addr_q.push_back(bus.PADDR);
      wr_data_q.push_back(bus.PWDATA);
    end
    if (bus.frame_done) begin
      fd_cnt++;
      fd_cyc = cyc_n;
    end
  end

  function automatic logic [AW-1:0] exp_word(input int first);
    return AW'({pix_q[first+2], pix_q[first+1], pix_q[first]});
  endfunction

  task automatic fill_q(input int mul, input int add, input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(8'((i * mul + add) % 256));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
    fd_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Offers pix_q[first..first+n-1]; each acceptance is logged with its cycle.
  task automatic drive(input int first, input int n, input bit stall, input bit keep);
    int sent   = 0;
    int budget = (stall ? 6 : 2) * n + 50;
    for (int c = 0; c < budget && sent < n; c++) begin
      @(negedge clk);
      bus.pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = pix_q[first + sent];
      if (bus.pix_valid && bus.pix_ready) begin
        acc_q.push_back(cyc_n);
        sent++;
      end
    end
    if (!keep) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
    end
    n_checks++;
    if (sent !== n) $display("FAIL drive_count: accepted %0d pixels, required %0d", sent, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) $display("FAIL rst_apb_ctl: got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); else n_pass++;
    n_checks++; if (bus.PADDR !== '0) $display("FAIL rst_paddr: got %h want 0", bus.PADDR); else n_pass++;
    n_checks++; if (bus.PWDATA !== '0) $display("FAIL rst_pwdata: got %h want 0", bus.PWDATA); else n_pass++;
    n_checks++; if ({bus.frame_done, bus.busy, bus.pix_ready} !== 3'b000) $display("FAIL rst_status: got %b want 000", {bus.frame_done, bus.busy, bus.pix_ready}); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.pix_ready !== 1'b0) $display("FAIL rst_ready_before_edge: got %b want 0", bus.pix_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.pix_ready !== 1'b1) $display("FAIL rst_ready_after_edge: got %b want 1", bus.pix_ready); else n_pass++;
  endtask

  task automatic test_single_word();
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'h11;
    @(negedge clk);
    bus.pix_data = 8'h22;
    n_checks++; if (bus.PSEL !== 1'b0) $display("FAIL sw_psel_idle: got %b want 0", bus.PSEL); else n_pass++;
    @(negedge clk);
    bus.pix_data = 8'h33;
    @(negedge clk);
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) $display("FAIL sw_setup_ctl: got %b want 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); else n_pass++;
    n_checks++; if (bus.PADDR !== 13'd1) $display("FAIL sw_setup_addr: got %0d want 1", bus.PADDR); else n_pass++;
    n_checks++; if (bus.PWDATA !== 24'h332211) $display("FAIL sw_setup_data: got %h want 332211", bus.PWDATA); else n_pass++;
    n_checks++; if ({bus.pix_ready, bus.busy} !== 2'b01) $display("FAIL sw_setup_ready_busy: got %b want 01", {bus.pix_ready, bus.busy}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.pix_ready} !== 3'b110) $display("FAIL sw_access: psel/penable/ready got %b want 110", {bus.PSEL, bus.PENABLE, bus.pix_ready}); else n_pass++;
    n_checks++; if ({bus.PADDR, bus.PWDATA} !== {13'd1, 24'h332211}) $display("FAIL sw_access_hold: got %h/%h want 1/332211", bus.PADDR, bus.PWDATA); else n_pass++;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.pix_ready} !== 4'b0001) $display("FAIL sw_after: psel/penable/pwrite/ready got %b want 0001", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.pix_ready}); else n_pass++;
    n_checks++; if ({bus.PADDR, bus.PWDATA} !== {13'd1, 24'h332211}) $display("FAIL sw_idle_hold: got %h/%h want 1/332211", bus.PADDR, bus.PWDATA); else n_pass++;
  endtask

  task automatic test_stall();
    int bad = 0;
    do_reset();
    fill_q(37, 5, 30);
    drive(0, 2, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    n_checks++; if ({bus.PSEL, bus.pix_ready} !== 2'b01) $display("FAIL stall_pause: psel/ready got %b want 01", {bus.PSEL, bus.pix_ready}); else n_pass++;
    drive(2, 28, 1'b1, 1'b0);
    for (int i = 0; i < 20 && wr_addr_q.size() < 10; i++) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== 10) $display("FAIL stall_write_count: got %0d want 10", wr_addr_q.size()); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (k >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[k] !== AW_ADDR'(k + 1) || wr_data_q[k] !== exp_word(3 * k)) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL stall_words: %0d bad words, want 0", bad); else n_pass++;
  endtask

  task automatic test_full_frame();
    int bad = 0;
    int first_bad = -1;
    do_reset();
    fill_q(1, 0, FRAME_PIX);
    drive(0, FRAME_PIX, 1'b0, 1'b0);
    for (int i = 0; i < 20 && fd_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== FRAME_WRD + 1) $display("FAIL ff_write_count: got %0d want %0d", wr_addr_q.size(), FRAME_WRD + 1); else n_pass++;
    for (int k = 0; k < FRAME_WRD; k++) begin
      if (k >= wr_addr_q.size() || wr_addr_q[k] !== AW_ADDR'(k + 1) || wr_data_q[k] !== exp_word(3 * k)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL ff_words: %0d bad words (first index %0d), want 0", bad, first_bad); else n_pass++;
    n_checks++;
    if (wr_addr_q.size() <= FRAME_WRD) $display("FAIL ff_start_write: missing, want addr 0 data 1");
    else if ({wr_addr_q[FRAME_WRD], wr_data_q[FRAME_WRD]} !== {13'd0, 24'd1}) $display("FAIL ff_start_write: got addr %0d data %h want 0/1", wr_addr_q[FRAME_WRD], wr_data_q[FRAME_WRD]);
    else n_pass++;
    n_checks++; if (fd_cnt !== 1) $display("FAIL ff_frame_done_cycles: got %0d want 1", fd_cnt); else n_pass++;
    n_checks++; if ({bus.busy, bus.pix_ready} !== 2'b01) $display("FAIL ff_after: busy/ready got %b want 01", {bus.busy, bus.pix_ready}); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int zeros = 0;
    do_reset();
    fill_q(1, 0, 6000);
    drive(0, 6000, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !(bus.PSEL && bus.PENABLE); i++) @(negedge clk);
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PADDR} !== {2'b11, 13'd2000}) $display("FAIL rm_access_2000: got psel/penable %b%b addr %0d want 11/2000", bus.PSEL, bus.PENABLE, bus.PADDR); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.pix_ready} !== 4'b0000) $display("FAIL rm_async_clear: got %b want 0000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.pix_ready}); else n_pass++;
    n_checks++; if ({bus.PADDR, bus.PWDATA} !== {13'd0, 24'd0}) $display("FAIL rm_async_bus: got %h/%h want 0/0", bus.PADDR, bus.PWDATA); else n_pass++;
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
    fd_cnt = 0;
    rst = 1'b1;
    fill_q(5, 3, FRAME_PIX + 3);
    drive(0, FRAME_PIX, 1'b0, 1'b1);
    foreach (wr_addr_q[k]) if (wr_addr_q[k] === '0) zeros++;
    n_checks++; if (zeros !== 0) $display("FAIL rm_no_addr0: got %0d writes to 0 want 0", zeros); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== FRAME_WRD - 1) $display("FAIL rm_write_count: got %0d want %0d", wr_addr_q.size(), FRAME_WRD - 1); else n_pass++;
    n_checks++;
    if (wr_addr_q.size() == 0) $display("FAIL rm_first_write: missing, want addr 1 data %h", exp_word(0));
    else if ({wr_addr_q[0], wr_data_q[0]} !== {13'd1, exp_word(0)}) $display("FAIL rm_first_write: got addr %0d data %h want 1/%h", wr_addr_q[0], wr_data_q[0], exp_word(0));
    else n_pass++;
  endtask

  // Continues straight on from test_reset_mid_frame with pix_valid still high.
  task automatic test_back_to_back();
    int bad = 0;
    acc_q.delete();
    drive(FRAME_PIX, 3, 1'b0, 1'b0);
    for (int i = 0; i < 20 && wr_addr_q.size() < FRAME_WRD + 2; i++) @(negedge clk);
    n_checks++; if (wr_addr_q.size() !== FRAME_WRD + 2) $display("FAIL b2b_write_count: got %0d want %0d", wr_addr_q.size(), FRAME_WRD + 2); else n_pass++;
    for (int k = 0; k < FRAME_WRD; k++) begin
      if (k >= wr_addr_q.size() || wr_addr_q[k] !== AW_ADDR'(k + 1) || wr_data_q[k] !== exp_word(3 * k)) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL b2b_frame_words: %0d bad words want 0", bad); else n_pass++;
    n_checks++;
    if (wr_addr_q.size() < FRAME_WRD + 2) $display("FAIL b2b_tail_writes: missing start/next writes");
    else if ({wr_addr_q[FRAME_WRD], wr_data_q[FRAME_WRD], wr_addr_q[FRAME_WRD+1], wr_data_q[FRAME_WRD+1]} !== {13'd0, 24'd1, 13'd1, exp_word(FRAME_PIX)})
      $display("FAIL b2b_tail_writes: got %0d/%h then %0d/%h want 0/1 then 1/%h", wr_addr_q[FRAME_WRD], wr_data_q[FRAME_WRD], wr_addr_q[FRAME_WRD+1], wr_data_q[FRAME_WRD+1], exp_word(FRAME_PIX));
    else n_pass++;
    n_checks++; if (fd_cnt !== 1) $display("FAIL b2b_frame_done_cycles: got %0d want 1", fd_cnt); else n_pass++;
    n_checks++;
    if (acc_q.size() == 0) $display("FAIL b2b_first_accept: no acceptance, want cycle %0d", fd_cyc + 1);
    else if (acc_q[0] !== fd_cyc + 1) $display("FAIL b2b_first_accept: got cycle %0d want %0d", acc_q[0], fd_cyc + 1);
    else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else n_pass++;
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    test_reset();
    test_single_word();
    test_stall();
    test_full_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_apb_loader.md
PIXEL_APB_LOADER -- requirements
Module: pixel_apb_loader

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- Amba_Word, 24, APB data width (24 or 32).
- Amba_Addr_Depth, 12, APB address MSB index (12/13/14).
REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock; one clock domain only.
- rst, in, 1, reset; asynchronous, active-low.
- pix_valid, in, 1, upstream pixel valid.
- pix_data, in, 8, unsigned pixel.
- pix_ready, out, 1, loader accepts a pixel this cycle.
- PSEL, out, 1, APB select.
- PENABLE, out, 1, APB enable.
- PWRITE, out, 1, APB write; this block only writes.
- PADDR, out, Amba_Addr_Depth+1, APB address.
- PWDATA, out, Amba_Word, APB write data.
- frame_done, out, 1, one-cycle pulse after the start-register write completes.
- busy, out, 1, a frame is in progress (at least 1 pixel taken, frame_done not yet pulsed).

Function
REQ-003 A pixel SHALL transfer on a rising clk edge only when pix_valid and pix_ready are both 1.
REQ-004 Packing SHALL use a 2-bit lane counter (0..2):
- Pixel at lane 0 goes to PWDATA[7:0], lane 1 to [15:8], lane 2 to [23:16].
- When Amba_Word=32, bits [31:24] SHALL be 0.
REQ-005 FSM states SHALL be FILL, W_SETUP, W_ACCESS, S_SETUP, S_ACCESS, DONE.
REQ-006 FILL behaviour:
- pix_ready=1 and PSEL=0.
- Accepting the lane-2 pixel moves to W_SETUP on the next cycle.
REQ-007 W_SETUP SHALL drive PSEL=1, PENABLE=0, PWRITE=1, with PADDR = word counter and PWDATA = packed word, then go to W_ACCESS.
REQ-008 W_ACCESS SHALL drive PSEL=1 and PENABLE=1, with PADDR and PWDATA unchanged, for exactly one cycle.
REQ-009 After W_ACCESS, the word counter and the next state SHALL be:
- Counter < 4096: increment the counter and go to FILL.
- Counter = 4096: go to S_SETUP.
REQ-010 The word counter SHALL run 1..4096 inclusive; address 0 is never used for pixel data.
REQ-011 S_SETUP and S_ACCESS SHALL use the same two-cycle APB write as W_SETUP/W_ACCESS, with PADDR=0 and PWDATA=1 (start register).
REQ-012 After S_ACCESS, the FSM SHALL enter DONE for one cycle, assert frame_done, reset the word counter to 1 and the lane counter to 0, then return to FILL.
REQ-013 pix_ready SHALL be 0 in every state except FILL.
- Worst-case throughput is 3 pixels per 5 cycles.
REQ-014 Outside the SETUP and ACCESS states:
- PSEL, PENABLE, PWRITE SHALL be 0.
- PADDR and PWDATA SHALL hold their last values.
REQ-015 pix_valid deasserting mid-word SHALL stall packing with no loss; lane contents are kept indefinitely.
REQ-016 A frame SHALL be exactly 12288 pixels; there is no partial-frame flush.

Reset
REQ-017 While rst=0, the block SHALL immediately (asynchronously) force:
- state = FILL, lane counter = 0, word counter = 1;
- PSEL = PENABLE = PWRITE = 0;
- PADDR = 0, PWDATA = 0;
- frame_done = 0, busy = 0;
- pix_ready = 0.
REQ-018 pix_ready SHALL rise on the first clk edge after rst returns to 1.
REQ-019 Reset mid-frame, including mid-APB-access, SHALL abandon the frame; no further APB cycle for it SHALL be issued.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state encoding;
- PIXELS_PER_WORD=3;
- WORDS_PER_FRAME=4096;
- START_REG_ADDR=0;
- PIXEL_WIDTH=8.
REQ-021 One sub-module, apb_write_master, SHALL implement the two-cycle SETUP/ACCESS sequencing.
- Interface: req, addr, data in; done pulse out.
- The FSM SHALL use it for both word writes and the start write.

Verification
REQ-022 Single word: pixels 0x11, 0x22, 0x33 with pix_valid held high SHALL produce:
- PSEL rising 1 cycle after the third acceptance;
- PADDR=1, PWDATA=0x332211 (0x00332211 when Amba_Word=32);
- PENABLE high on the next cycle;
- pix_ready low for exactly 2 cycles.
REQ-023 Full frame: 12288 pixels of value (i mod 256) SHALL produce:
- 4096 writes to addresses 1..4096 in order;
- then a write of 1 to address 0;
- frame_done high for exactly 1 cycle;
- busy low afterwards.
REQ-024 Stall: pix_valid toggled randomly SHALL leave PWDATA for every word identical to the unstalled run.
REQ-025 Reset at word 2000 (during W_ACCESS): after release, the next write SHALL target address 1 with the first three new pixels, and no write to address 0 SHALL occur before 12288 new pixels.
- Reset assertion SHALL clear PSEL within the same cycle, without waiting for a clock edge.
REQ-026 Back-to-back frames: the second frame's first accepted pixel SHALL occur 1 cycle after frame_done and SHALL produce a write to address 1.
